// File: rtl/ppa_mult_pkg.sv
// ppa_mult_pkg
// Shared definitions for the PPA8-based sequential multiplier:
//   - FSM state encoding (IDLE / CALC / DONE)
//   - operand/product widths and number of add-and-shift steps
package ppa_mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MULT_W   = 8;
    localparam int PROD_W   = 16;
    localparam int STEP_CNT = 8;

    // Step counter value on the final add-and-shift step.
    localparam logic [2:0] CNT_LAST = 3'(STEP_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE
    } mult_state_e;

endpackage

// File: rtl/ppa8_seq_mult_ppa8.sv
// ppa8
// 8-bit parallel-prefix (Kogge-Stone) adder: {cout, sum} = a + b + cin.
// Ports:
//   a, b  in   8  addends
//   cin   in   1  carry in
//   sum   out  8  sum bits
//   cout  out  1  carry out (9th bit of the result)
module ppa8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g0_s, p0_s;
    logic [7:0] g1_s, p1_s;
    logic [7:0] g2_s, p2_s;
    logic [7:0] g3_s, p3_s;
    logic [8:0] carry_s;

    assign g0_s = a & b;
    assign p0_s = a ^ b;

    // Prefix levels at span 1, 2, 4. Positions below the span are padded with
    // the identity element (g=0, p=1) so each bit's group reaches down to bit 0.
    assign g1_s = g0_s | (p0_s & {g0_s[6:0], 1'b0});
    assign p1_s = p0_s & {p0_s[6:0], 1'b1};

    assign g2_s = g1_s | (p1_s & {g1_s[5:0], 2'b00});
    assign p2_s = p1_s & {p1_s[5:0], 2'b11};

    assign g3_s = g2_s | (p2_s & {g2_s[3:0], 4'b0000});
    assign p3_s = p2_s & {p2_s[3:0], 4'b1111};

    // carry_s[i] is the carry into bit i; group terms span bits [i-1:0].
    assign carry_s = {g3_s | (p3_s & {8{cin}}), cin};

    assign sum  = p0_s ^ carry_s[7:0];
    assign cout = carry_s[8];

endmodule

// File: rtl/ppa8_seq_mult.sv
// ppa8_seq_mult
// Sequential unsigned 8x8 -> 16 shift-and-add multiplier using one ppa8 adder.
// One add-and-shift step per cycle for 8 cycles, then the product is held in
// DONE until the consumer takes it.
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-high reset
//   in_valid     in   1   operand pair valid
//   in_ready     out  1   operand pair can be accepted this cycle
//   in_a         in   8   multiplicand
//   in_b         in   8   multiplier
//   out_valid    out  1   out_product holds a finished result
//   out_ready    in   1   consumer accepts the result
//   out_product  out  16  in_a * in_b
//   busy         out  1   high while computing
import ppa_mult_pkg::*;

module ppa8_seq_mult #(
    parameter int WIDTH    = 8,
    parameter bit PIPE_B2B = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_product,
    output logic              busy
);

    // The shared adder is fixed at 8 bits.
    if (WIDTH != MULT_W) begin : g_bad_width
        $error("ppa8_seq_mult: WIDTH must be 8");
    end

    mult_state_e       state_r, state_s;
    logic [MULT_W-1:0] mcand_r;
    logic [MULT_W-1:0] acc_hi_r;
    logic [MULT_W-1:0] acc_lo_r;
    logic [2:0]        cnt_r;

    logic              load_s;
    logic              step_s;
    logic              in_ready_s;
    logic [MULT_W-1:0] addend_s;
    logic [MULT_W-1:0] sum_s;
    logic              cout_s;

    // Partial product for this step: multiplicand gated by the current multiplier LSB.
    always_comb begin
        addend_s = 8'h00;
        if (acc_lo_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = 8'h00;
        end
    end

    ppa8 u_ppa8 (
        .a    (acc_hi_r),
        .b    (addend_s),
        .cin  (1'b0),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Next-state, load/step strobes and input-ready decode.
    always_comb begin
        state_s    = state_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        in_ready_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    load_s  = 1'b1;
                    state_s = S_CALC;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CALC: begin
                step_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_CALC;
                end
            end
            S_DONE: begin
                // Back-to-back mode lets a new pair in on the output handshake cycle.
                if (PIPE_B2B == 1'b1) begin
                    in_ready_s = out_ready;
                end else begin
                    in_ready_s = 1'b0;
                end
                if (out_ready) begin
                    if ((PIPE_B2B == 1'b1) && in_valid) begin
                        load_s  = 1'b1;
                        state_s = S_CALC;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand load and add-and-shift datapath; Cout becomes acc_hi[7].
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= 8'h00;
            acc_hi_r <= 8'h00;
            acc_lo_r <= 8'h00;
            cnt_r    <= 3'd0;
        end else if (load_s) begin
            mcand_r  <= in_a;
            acc_hi_r <= 8'h00;
            acc_lo_r <= in_b;
            cnt_r    <= 3'd0;
        end else if (step_s) begin
            {acc_hi_r, acc_lo_r} <= {cout_s, sum_s, acc_lo_r[7:1]};
            cnt_r                <= cnt_r + 3'd1;
        end else begin
            mcand_r  <= mcand_r;
            acc_hi_r <= acc_hi_r;
            acc_lo_r <= acc_lo_r;
            cnt_r    <= cnt_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = (state_r == S_DONE);
    assign busy        = (state_r == S_CALC);
    assign out_product = {acc_hi_r, acc_lo_r};

endmodule
